stream_sink_chk: RTL and testbench

Receiving end of the 8-bit valid/ready stream carried by the pipeline relay stages: accepts beats from a relay output, applies a programmable backpressure pattern on `ready_o`, and checks that accepted data is a wrapping +1 sequence. Counts accepted beats and sequence errors for bench and bring-up observation. Sits downstream of the relay as its sink, paired with an upstream counting source.

---
 rtl/stream_pkg.sv | 25 ++
 rtl/lfsr8.sv | 34 +++
 rtl/stream_sink_chk.sv | 132 +++++++++++++
 tb/tb_stream_sink_chk.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared types for the stream sink checker: data width default,
// backpressure mode encodings, checker FSM states and the LFSR step.
package stream_pkg;

    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        BP_ALWAYS   = 2'd0,
        BP_LFSR     = 2'd1,
        BP_STALL    = 2'd2,
        BP_PERIODIC = 2'd3
    } bp_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        CHECK = 2'd2
    } state_e;

    // Fibonacci step for x^8+x^6+x^5+x^4+1, shifting towards the MSB.
    function automatic logic [7:0] lfsr8_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) with seed and step enable.
// Ports: clk, rst (async active-low), en (advance), q (current state).
module lfsr8
    import stream_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [7:0] q
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en) begin
            lfsr_d = lfsr8_step(lfsr_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/stream_sink_chk.sv
// Stream sink: drives a programmable backpressure pattern on ready_o and
// checks that accepted data forms a wrapping +1 sequence.
// Ports: clk, rst (async active-low), en, bp_mode, valid_i, din in;
//        ready_o, beat_cnt, err_cnt, err_o, exp_o out.
module stream_sink_chk
    import stream_pkg::*;
#(
    parameter int         DATA_W    = DEF_DATA_W,
    parameter int         CNT_W     = 16,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        bp_mode,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] din,
    output logic              ready_o,
    output logic [CNT_W-1:0]  beat_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              err_o,
    output logic [DATA_W-1:0] exp_o
);

    state_e              state_q, state_d;
    logic                ready_q, ready_d;
    logic [CNT_W-1:0]    beat_q, beat_d;
    logic [CNT_W-1:0]    errc_q, errc_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   exp_q, exp_d;
    logic [2:0]          phase_q, phase_d;
    logic [7:0]          lfsr_q;
    logic                hs;
    logic                unused_lfsr;

    // Free-running: advances in every state, including IDLE.
    lfsr8 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .q   (lfsr_q)
    );

    assign unused_lfsr = ^lfsr_q[7:1];
    assign hs          = valid_i && ready_q;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        errc_d  = errc_q;
        err_d   = err_q;
        exp_d   = exp_q;
        ready_d = 1'b0;
        phase_d = phase_q + 3'd1;

        unique case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = SYNC;
                    beat_d  = '0;
                    errc_d  = '0;
                    err_d   = 1'b0;
                    exp_d   = '0;
                end
            end
            SYNC: begin
                // First beat only seeds the expectation.
                if (hs) begin
                    beat_d  = beat_q + CNT_W'(~&beat_q);
                    exp_d   = din + 1'b1;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (hs) begin
                    beat_d = beat_q + CNT_W'(~&beat_q);
                    if (din != exp_q) begin
                        errc_d = errc_q + CNT_W'(~&errc_q);
                        err_d  = 1'b1;
                        exp_d  = din + 1'b1;
                    end else begin
                        exp_d  = exp_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A handshake on the falling-en edge is still processed above.
        if (!en) begin
            state_d = IDLE;
        end

        if (en && state_q != IDLE) begin
            unique case (bp_mode_e'(bp_mode))
                BP_ALWAYS:   ready_d = 1'b1;
                BP_LFSR:     ready_d = lfsr_q[0];
                BP_STALL:    ready_d = 1'b0;
                BP_PERIODIC: ready_d = ~phase_q[2];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            beat_q  <= '0;
            errc_q  <= '0;
            err_q   <= 1'b0;
            exp_q   <= '0;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            beat_q  <= beat_d;
            errc_q  <= errc_d;
            err_q   <= err_d;
            exp_q   <= exp_d;
            phase_q <= phase_d;
        end
    end

    assign ready_o  = ready_q;
    assign beat_cnt = beat_q;
    assign err_cnt  = errc_q;
    assign err_o    = err_q;
    assign exp_o    = exp_q;

endmodule

// File: tb/tb_stream_sink_chk.sv
// Bench for stream_sink_chk: vector table plus directed runs for
// backpressure modes, reset mid-run and error-counter saturation.
module tb_stream_sink_chk;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  bp_mode = 2'd0;
    logic        valid_i = 1'b0;
    logic [7:0]  din = 8'h00;

    logic        ready_o;
    logic [15:0] beat_cnt;
    logic [15:0] err_cnt;
    logic        err_o;
    logic [7:0]  exp_o;

    logic        s_ready;
    logic [3:0]  s_beat;
    logic [3:0]  s_err;
    logic        s_erro;
    logic [7:0]  s_exp;

    int checks = 0;
    int errors = 0;

    logic [7:0] lfsr_m;
    logic [2:0] ph_m;

    stream_sink_chk #(
        .DATA_W    (8),
        .CNT_W     (16),
        .LFSR_SEED (8'hA5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .bp_mode  (bp_mode),
        .valid_i  (valid_i),
        .din      (din),
        .ready_o  (ready_o),
        .beat_cnt (beat_cnt),
        .err_cnt  (err_cnt),
        .err_o    (err_o),
        .exp_o    (exp_o)
    );

    stream_sink_chk #(
        .DATA_W    (8),
        .CNT_W     (4),
        .LFSR_SEED (8'hA5)
    ) dut_small (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .bp_mode  (bp_mode),
        .valid_i  (valid_i),
        .din      (din),
        .ready_o  (s_ready),
        .beat_cnt (s_beat),
        .err_cnt  (s_err),
        .err_o    (s_erro),
        .exp_o    (s_exp)
    );

    always #5 clk = ~clk;

    // Reference LFSR and phase counter, both free-running from reset.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_m <= 8'hA5;
            ph_m   <= 3'd0;
        end else begin
            lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
            ph_m   <= ph_m + 3'd1;
        end
    end

    typedef struct {
        logic        en;
        logic [1:0]  bp;
        logic        v;
        logic [7:0]  d;
        logic        rdy;
        logic [15:0] beat;
        logic [15:0] ec;
        logic        eo;
        logic [7:0]  ex;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        en = 1'b0;
        valid_i = 1'b0;
        bp_mode = 2'd0;
        din = 8'h00;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " ready"}, 32'(ready_o), 0);
        chk({nm, " beat"}, 32'(beat_cnt), 0);
        chk({nm, " errc"}, 32'(err_cnt), 0);
        chk({nm, " erro"}, 32'(err_o), 0);
        chk({nm, " exp"}, 32'(exp_o), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int got;
        int acc;
        int cyc;
        logic hs;
        logic prev_exp;
        logic exp_r;
        logic [7:0] m_pre;
        logic [2:0] p_pre;
        logic [15:0] b0;

        tbl[0]  = '{1'b1, 2'd0, 1'b0, 8'h00, 1'b0, 16'd0, 16'd0, 1'b0, 8'h00};
        tbl[1]  = '{1'b1, 2'd0, 1'b1, 8'h08, 1'b1, 16'd0, 16'd0, 1'b0, 8'h00};
        tbl[2]  = '{1'b1, 2'd0, 1'b1, 8'h08, 1'b1, 16'd1, 16'd0, 1'b0, 8'h09};
        tbl[3]  = '{1'b1, 2'd0, 1'b1, 8'h09, 1'b1, 16'd2, 16'd0, 1'b0, 8'h0A};
        tbl[4]  = '{1'b1, 2'd0, 1'b1, 8'h0B, 1'b1, 16'd3, 16'd1, 1'b1, 8'h0C};
        tbl[5]  = '{1'b1, 2'd0, 1'b1, 8'h0C, 1'b1, 16'd4, 16'd1, 1'b1, 8'h0D};
        tbl[6]  = '{1'b1, 2'd0, 1'b0, 8'h0D, 1'b1, 16'd4, 16'd1, 1'b1, 8'h0D};
        tbl[7]  = '{1'b0, 2'd0, 1'b1, 8'h0D, 1'b0, 16'd5, 16'd1, 1'b1, 8'h0E};
        tbl[8]  = '{1'b0, 2'd0, 1'b1, 8'h0E, 1'b0, 16'd5, 16'd1, 1'b1, 8'h0E};
        tbl[9]  = '{1'b1, 2'd0, 1'b0, 8'h00, 1'b0, 16'd0, 16'd0, 1'b0, 8'h00};
        tbl[10] = '{1'b1, 2'd0, 1'b1, 8'hFF, 1'b1, 16'd0, 16'd0, 1'b0, 8'h00};
        tbl[11] = '{1'b1, 2'd0, 1'b1, 8'hFF, 1'b1, 16'd1, 16'd0, 1'b0, 8'h00};
        tbl[12] = '{1'b1, 2'd0, 1'b1, 8'h00, 1'b1, 16'd2, 16'd0, 1'b0, 8'h01};
        tbl[13] = '{1'b1, 2'd2, 1'b1, 8'h01, 1'b0, 16'd3, 16'd0, 1'b0, 8'h02};
        tbl[14] = '{1'b1, 2'd2, 1'b1, 8'h02, 1'b0, 16'd3, 16'd0, 1'b0, 8'h02};

        // Reset values, then the vector table.
        do_reset();
        chk_zero("reset");
        for (int i = 0; i < 15; i++) begin
            en = tbl[i].en;
            bp_mode = tbl[i].bp;
            valid_i = tbl[i].v;
            din = tbl[i].d;
            tick();
            chk($sformatf("vec%0d ready", i), 32'(ready_o), 32'(tbl[i].rdy));
            chk($sformatf("vec%0d beat", i), 32'(beat_cnt), 32'(tbl[i].beat));
            chk($sformatf("vec%0d errc", i), 32'(err_cnt), 32'(tbl[i].ec));
            chk($sformatf("vec%0d erro", i), 32'(err_o), 32'(tbl[i].eo));
            chk($sformatf("vec%0d exp", i), 32'(exp_o), 32'(tbl[i].ex));
        end

        // Mode 0: 300 continuous beats through the 8'hFF wrap.
        do_reset();
        en = 1'b1;
        valid_i = 1'b1;
        din = 8'h00;
        tick();
        chk("A first ready", 32'(ready_o), 0);
        got = 0;
        cyc = 0;
        prev_exp = 1'b0;
        while (got < 300 && cyc < 400) begin
            hs = prev_exp;
            tick();
            cyc++;
            chk("A ready", 32'(ready_o), 1);
            prev_exp = 1'b1;
            if (hs) begin
                din++;
                got++;
            end
        end
        valid_i = 1'b0;
        chk("A budget", 32'(got), 300);
        chk("A beat", 32'(beat_cnt), 300);
        chk("A errc", 32'(err_cnt), 0);
        chk("A erro", 32'(err_o), 0);
        chk("A exp", 32'(exp_o), 32'h2C);

        // Mode 1: LFSR backpressure, 200 beats, data held until accepted.
        do_reset();
        bp_mode = 2'd1;
        en = 1'b1;
        valid_i = 1'b1;
        din = 8'h30;
        tick();
        chk("B first ready", 32'(ready_o), 0);
        got = 0;
        cyc = 0;
        prev_exp = 1'b0;
        while (got < 200 && cyc < 2000) begin
            m_pre = lfsr_m;
            hs = prev_exp;
            tick();
            cyc++;
            exp_r = m_pre[0];
            chk("B ready", 32'(ready_o), 32'(exp_r));
            prev_exp = exp_r;
            if (hs) begin
                din++;
                got++;
            end
        end
        chk("B budget", 32'(got), 200);
        chk("B beat", 32'(beat_cnt), 200);
        chk("B errc", 32'(err_cnt), 0);
        chk("B exp", 32'(exp_o), 32'hF8);

        // Mode 2 stall for 50 cycles, then mode 3 periodic.
        valid_i = 1'b0;
        bp_mode = 2'd2;
        tick();
        chk("C stall ready0", 32'(ready_o), 0);
        b0 = beat_cnt;
        valid_i = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("C stall ready", 32'(ready_o), 0);
        end
        chk("C stall beat", 32'(beat_cnt), 32'(b0));
        bp_mode = 2'd3;
        acc = 0;
        prev_exp = 1'b0;
        for (int i = 0; i < 24; i++) begin
            p_pre = ph_m;
            hs = prev_exp;
            tick();
            exp_r = ~p_pre[2];
            chk("C per ready", 32'(ready_o), 32'(exp_r));
            prev_exp = exp_r;
            if (hs) begin
                din++;
                acc++;
            end
        end
        chk("C per beat", 32'(beat_cnt), 32'(b0) + 32'(acc));
        chk("C per rate", 32'(acc <= 12), 1);
        chk("C per errc", 32'(err_cnt), 0);

        // Reset in the middle of a run at beat 37, then a fresh run.
        do_reset();
        en = 1'b1;
        valid_i = 1'b1;
        din = 8'h00;
        tick();
        tick();
        for (int i = 0; i < 37; i++) begin
            tick();
            din++;
        end
        chk("D beat37", 32'(beat_cnt), 37);
        #2;
        rst = 1'b0;
        #1;
        chk_zero("D in reset");
        tick();
        chk_zero("D held reset");
        en = 1'b0;
        rst = 1'b1;
        tick();
        en = 1'b1;
        din = 8'd77;
        tick();
        tick();
        chk("D ready", 32'(ready_o), 1);
        tick();
        chk("D beat1", 32'(beat_cnt), 1);
        chk("D errc1", 32'(err_cnt), 0);
        chk("D exp1", 32'(exp_o), 78);
        din = 8'd78;
        tick();
        chk("D beat2", 32'(beat_cnt), 2);
        chk("D errc2", 32'(err_cnt), 0);
        chk("D erro2", 32'(err_o), 0);

        // Alternating bad data saturates the 4-bit error counter.
        do_reset();
        en = 1'b1;
        valid_i = 1'b1;
        din = 8'h55;
        tick();
        tick();
        for (int i = 0; i < 20; i++) begin
            tick();
            din = (din == 8'h55) ? 8'hAA : 8'h55;
            if (i == 15) begin
                chk("E sat at 15", 32'(s_err), 15);
            end
        end
        chk("E big beat", 32'(beat_cnt), 20);
        chk("E big errc", 32'(err_cnt), 19);
        chk("E small errc", 32'(s_err), 15);
        chk("E small erro", 32'(s_erro), 1);
        chk("E small beat", 32'(s_beat), 15);
        chk("E big erro", 32'(err_o), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
